seq_det_ctrl: RTL and testbench

Frame controller that drives the serial sequence detector (`seq_detector`: `x`, `clk`, `reset`, `z`). It accepts parallel bytes over a valid/ready handshake and clears the detector at each frame start. It shifts the bytes MSB-first onto the detector's `x` input and counts `z` pulses across the frame. At frame end it reports the match count, so software-side producers never need bit-level timing.

---
 rtl/seq_det_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame controller for a serial sequence detector.
// Accepts parallel words over valid/ready, clears the detector at frame
// start, shifts words MSB-first onto det_x and counts det_z pulses over the
// frame, reporting the count at frame end.
// Build option: define SEQ_DET_CTRL_SAT_EN to saturate the match counter
// instead of letting it wrap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for the first word of a frame, in_ready high
// S_CLR    | one-cycle det_rst pulse, accumulator cleared, frame opened
// S_SHIFT  | serialising the current word MSB-first onto det_x
// S_GAP    | producer stalled mid-frame, feeding 0 bits, underrun high
// S_DRAIN  | DET_LAT zero bits so the last z pulses can arrive
// S_REPORT | match_cnt updated, cnt_valid high, frame closed
module seq_det_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int DET_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              det_x,
  output logic              det_rst,
  input  logic              det_z,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              cnt_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DRN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_GAP,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sreg, sreg_nxt;
  logic [BIT_W-1:0]   bitcnt, bitcnt_nxt;
  logic               last_q, last_nxt;
  logic [DRN_W-1:0]   drncnt, drncnt_nxt;
  logic [CNT_W-1:0]   acc, acc_nxt, acc_inc;
  logic               frame_open, frame_open_nxt;
  logic               ready_raw;
  logic               count_en;

  // in_ready is forced low while the reset is held
  assign in_ready = ready_raw & reset;
  assign busy     = (state != S_IDLE);

  // z is only meaningful while bits of an open frame are on the detector
  assign count_en = frame_open && det_z &&
                    ((state == S_SHIFT) || (state == S_GAP) || (state == S_DRAIN));

  // accumulator increment, wrapping or saturating depending on the build
  always_comb begin
`ifdef SEQ_DET_CTRL_SAT_EN
    acc_inc = (&acc) ? acc : acc + CNT_W'(1);
`else
    acc_inc = acc + CNT_W'(1);
`endif
  end

  // next-state and combinational outputs
  always_comb begin
    state_nxt      = state;
    sreg_nxt       = sreg;
    bitcnt_nxt     = bitcnt;
    last_nxt       = last_q;
    drncnt_nxt     = drncnt;
    frame_open_nxt = frame_open;
    acc_nxt        = acc;
    ready_raw      = 1'b0;
    det_rst        = 1'b0;
    underrun       = 1'b0;
    case (state)
      S_IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          sreg_nxt   = in_data;
          last_nxt   = in_last;
          bitcnt_nxt = BIT_W'(DATA_W - 1);
          state_nxt  = S_CLR;
        end
      end
      S_CLR: begin
        det_rst        = 1'b1;
        acc_nxt        = '0;
        frame_open_nxt = 1'b1;
        state_nxt      = S_SHIFT;
      end
      S_SHIFT: begin
        ready_raw = (bitcnt == '0) && !last_q;
        if (bitcnt != '0) begin
          sreg_nxt   = sreg << 1;
          bitcnt_nxt = bitcnt - 1'b1;
        end else if (last_q) begin
          drncnt_nxt = DRN_W'(DET_LAT - 1);
          state_nxt  = S_DRAIN;
        end else if (in_valid) begin
          sreg_nxt   = in_data;
          last_nxt   = in_last;
          bitcnt_nxt = BIT_W'(DATA_W - 1);
        end else begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        underrun  = 1'b1;
        ready_raw = 1'b1;
        if (in_valid) begin
          sreg_nxt   = in_data;
          last_nxt   = in_last;
          bitcnt_nxt = BIT_W'(DATA_W - 1);
          state_nxt  = S_SHIFT;
        end
      end
      S_DRAIN: begin
        if (drncnt == '0) begin
          state_nxt = S_REPORT;
        end else begin
          drncnt_nxt = drncnt - 1'b1;
        end
      end
      S_REPORT: begin
        frame_open_nxt = 1'b0;
        state_nxt      = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (count_en) begin
      acc_nxt = acc_inc;
    end
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sreg       <= '0;
      bitcnt     <= '0;
      last_q     <= 1'b0;
      drncnt     <= '0;
      acc        <= '0;
      frame_open <= 1'b0;
      det_x      <= 1'b0;
      match_cnt  <= '0;
      cnt_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      bitcnt     <= bitcnt_nxt;
      last_q     <= last_nxt;
      drncnt     <= drncnt_nxt;
      acc        <= acc_nxt;
      frame_open <= frame_open_nxt;
      // det_x presents the bit belonging to the state being entered
      det_x      <= (state_nxt == S_SHIFT) ? sreg_nxt[DATA_W-1] : 1'b0;
      // acc_nxt already holds a z sampled in the final DRAIN cycle
      cnt_valid  <= (state_nxt == S_REPORT);
      if (state_nxt == S_REPORT) begin
        match_cnt <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: frames are planned as per-cycle expectation
// timelines (bits, gaps, drain, report) and det_z is recorded so the
// reported count is the number of z samples inside the frame window.
`timescale 1ns/1ps
module tb_seq_det_ctrl;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int DET_LAT = 1;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int ASZ     = 8192;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              det_z = 1'b0;
  logic              in_ready, det_x, det_rst, cnt_valid, underrun, busy;
  logic [CNT_W-1:0]  match_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int next_free = 0;

  bit e_ready[ASZ], e_x[ASZ], e_rst[ASZ], e_und[ASZ], e_busy[ASZ], e_cv[ASZ], e_hs[ASZ];
  int rep_ws[ASZ];
  bit zplan[ASZ], z_hist[ASZ];
  bit o_x[ASZ], o_cv[ASZ], o_und[ASZ], o_rst[ASZ];
  int o_cnt[ASZ];

  logic [7:0] fw[16];
  int fg[16];
  int pt, pr, pn;
  int pb[16], pe[16];

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .det_x(det_x), .det_rst(det_rst),
    .det_z(det_z), .match_cnt(match_cnt), .cnt_valid(cnt_valid),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // det_z for cycle cyc+1 is driven just after the edge and remembered
  always @(posedge clk) begin
    #1;
    det_z = zplan[cyc+1];
    z_hist[cyc+1] = zplan[cyc+1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc + 1, act, exp);
    end
  endtask

  function automatic int model_count(input int n);
`ifdef SEQ_DET_CTRL_SAT_EN
    return (n > CMAX) ? CMAX : n;
`else
    return n % (CMAX + 1);
`endif
  endfunction

  // per-cycle compare against the planned timeline
  always @(negedge clk) begin
    int c;
    int n;
    c = cyc + 1;
    o_x[c] = det_x; o_cv[c] = cnt_valid; o_und[c] = underrun; o_rst[c] = det_rst;
    o_cnt[c] = int'(match_cnt);
    if (!reset) begin
      exp_cnt = 0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_det_x", det_x, 0);
      chk("rst_det_rst", det_rst, 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_cnt_valid", cnt_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_busy", busy, 0);
    end else begin
      if (rep_ws[c] != 0) begin
        n = 0;
        for (int k = rep_ws[c]; k < c; k++) n += int'(z_hist[k]);
        exp_cnt = model_count(n);
      end
      chk("in_ready", in_ready, int'(e_ready[c]));
      chk("det_x", det_x, int'(e_x[c]));
      chk("det_rst", det_rst, int'(e_rst[c]));
      chk("underrun", underrun, int'(e_und[c]));
      chk("busy", busy, int'(e_busy[c]));
      chk("cnt_valid", cnt_valid, int'(e_cv[c]));
      chk("match_cnt", match_cnt, exp_cnt);
      chk("handshake", in_valid && in_ready, int'(e_hs[c]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_hs();
    bit got;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        got = 1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL hs_timeout cycle %0d: got no handshake expected one", cyc + 1);
    end
    step();
  endtask

  // builds the expected timeline of one frame starting at the next legal idle cycle
  task automatic plan(input int nw, input int idle);
    int base;
    pn = nw;
    base = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    pt = base + idle;
    pb[0] = pt + 2;
    pe[0] = pt;
    for (int i = 1; i < nw; i++) begin
      pb[i] = pb[i-1] + DATA_W + fg[i];
      pe[i] = pb[i] - 1;
    end
    pr = pb[nw-1] + DATA_W + DET_LAT;
    for (int c = pt + 1; c <= pr; c++) begin
      e_ready[c] = 0; e_busy[c] = 1; e_x[c] = 0; e_und[c] = 0;
      e_rst[c] = 0; e_cv[c] = 0; e_hs[c] = 0; rep_ws[c] = 0;
    end
    e_rst[pt+1] = 1;
    for (int i = 0; i < nw; i++) begin
      e_hs[pe[i]] = 1;
      for (int k = 0; k < DATA_W; k++) e_x[pb[i]+k] = fw[i][DATA_W-1-k];
      if (i > 0) begin
        for (int c = pb[i] - fg[i]; c < pb[i]; c++) begin
          e_und[c] = 1;
          e_ready[c] = 1;
        end
      end
      if (i < nw - 1) e_ready[pb[i] + DATA_W - 1] = 1;
    end
    e_cv[pr] = 1;
    rep_ws[pr] = pt + 2;
  endtask

  task automatic drive(input bit early, input int rst_off);
    for (int i = 0; i < pn; i++) begin
      if (!(i == 0 && early)) begin
        in_valid = 0;
        while (cyc < pe[i] - 1) step();
      end
      in_valid = 1;
      in_data = fw[i];
      in_last = (i == pn - 1);
      wait_hs();
      in_valid = 0;
      in_last = 0;
      if (rst_off >= 0) begin
        while (cyc < pb[0] + rst_off - 1) step();
        reset = 0;
        for (int c = cyc + 1; c <= pr; c++) begin
          e_ready[c] = 1; e_busy[c] = 0; e_x[c] = 0; e_und[c] = 0;
          e_rst[c] = 0; e_cv[c] = 0; e_hs[c] = 0; rep_ws[c] = 0;
        end
        step();
        step();
        reset = 1;
        next_free = cyc + 1;
        return;
      end
    end
    next_free = pr + 1;
  endtask

  function automatic logic [31:0] collect(input int s, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v = {v[30:0], o_x[s+k]};
    return v;
  endfunction

  function automatic int und_count(input int s, input int e);
    int n;
    n = 0;
    for (int c = s; c <= e; c++) n += int'(o_und[c]);
    return n;
  endfunction

  function automatic int cv_offset(input int s, input int e);
    for (int c = s; c <= e; c++) if (o_cv[c]) return c - s;
    return -1;
  endfunction

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) fg[i] = 0;
  endtask

  task automatic zero_z(input int s, input int e);
    for (int c = s; c <= e; c++) zplan[c] = 0;
  endtask

  initial begin
    int nw, idle;
    bit early;
    for (int c = 0; c < ASZ; c++) begin
      e_ready[c] = 1;
      zplan[c] = bit'($urandom_range(0, 1));
    end
    clear_gaps();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    next_free = cyc + 1;

    // single word 0xA5, three z pulses during SHIFT
    fw[0] = 8'hA5;
    plan(1, 2);
    zero_z(pt, pr + 1);
    zplan[pb[0]+1] = 1; zplan[pb[0]+3] = 1; zplan[pb[0]+6] = 1;
    drive(0, -1);
    wait_until(pr + 1);
    chk("a5_bits", collect(pb[0], 8), 32'hA5);
    chk("a5_det_rst_pulse", o_rst[pt+1], 1);
    chk("a5_det_rst_width", o_rst[pt+2], 0);
    chk("a5_cnt_valid_at", cv_offset(pt, pr), 11);
    chk("a5_match_cnt", o_cnt[pr], 3);

    // gapless 0xF0, 0x0F
    clear_gaps();
    fw[0] = 8'hF0; fw[1] = 8'h0F;
    plan(2, 1);
    drive(0, -1);
    wait_until(pr + 1);
    chk("gapless_bits", collect(pb[0], 16), 32'hF00F);
    chk("gapless_underrun", und_count(pt, pr), 0);
    chk("gapless_cnt_valid_at", cv_offset(pt, pr), 19);

    // 0x80, two-cycle stall, then 0x01; z only in one GAP cycle
    clear_gaps();
    fw[0] = 8'h80; fw[1] = 8'h01; fg[1] = 2;
    plan(2, 1);
    zero_z(pt, pr + 1);
    zplan[pb[1]-1] = 1;
    drive(0, -1);
    wait_until(pr + 1);
    chk("gap_bits", collect(pb[0], 18), 32'h20001);
    chk("gap_underrun", und_count(pt, pr), 2);
    chk("gap_match_cnt", o_cnt[pr], 1);

    // twenty z pulses in one frame against a 4-bit counter
    clear_gaps();
    fw[0] = 8'h12; fw[1] = 8'h34; fw[2] = 8'h56;
    plan(3, 1);
    zero_z(pt, pr + 1);
    for (int c = pb[0]; c < pb[0] + 20; c++) zplan[c] = 1;
    drive(0, -1);
    wait_until(pr + 1);
`ifdef SEQ_DET_CTRL_SAT_EN
    chk("ovf_match_cnt", o_cnt[pr], 15);
`else
    chk("ovf_match_cnt", o_cnt[pr], 4);
`endif

    // reset during SHIFT of a two-word frame, then a fresh frame
    clear_gaps();
    fw[0] = 8'hC3; fw[1] = 8'h3C;
    plan(2, 1);
    drive(0, 3);
    chk("abort_match_cnt", match_cnt, 0);
    chk("abort_busy", busy, 0);
    fw[0] = 8'h3C;
    plan(1, 0);
    drive(0, -1);
    wait_until(pr + 1);
    chk("after_abort_clr", o_rst[pt+1], 1);
    chk("after_abort_cnt_valid_at", cv_offset(pt, pr), 11);

    // z held high outside the bit window; only the final DRAIN cycle counts
    clear_gaps();
    fw[0] = 8'h5A;
    plan(1, 3);
    for (int c = cyc + 2; c <= pr + 3; c++) zplan[c] = 1;
    zero_z(pb[0], pb[0] + DATA_W - 1);
    drive(0, -1);
    wait_until(pr + 1);
    chk("drain_only_cnt", o_cnt[pr], 1);

    // randomized frames, gaps, idle spacing and early offers
    for (int f = 0; f < 40; f++) begin
      clear_gaps();
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) begin
        fw[i] = 8'($urandom);
        if (i > 0 && $urandom_range(0, 2) == 0) fg[i] = $urandom_range(1, 3);
      end
      idle = $urandom_range(0, 3);
      early = (idle == 0) && ($urandom_range(0, 1) == 1);
      plan(nw, idle);
      drive(early, -1);
    end
    wait_until(pr + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
